// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 scan-code sequence decoder with key event FIFO
// Folds prefix bytes (E0/F0/E1) into {released, extended, code} events queued in a FWFT FIFO.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic [7:0]                   code_i,
  input  logic                         strobe_i,
  input  logic                         err_i,
  output logic [9:0]                   key_o,
  output logic                         valid_o,
  input  logic                         rd_i,
  output logic [$clog2(FIFO_DEPTH):0]  count_o,
  output logic                         overflow_o,
  input  logic                         clr_overflow_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic          push_req;
  logic [9:0]    push_data;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          full, empty, do_pop, do_push, drop;

  // Keyboard housekeeping bytes (errors, BAT result, echo, ack, resend) carry no key.
  function automatic logic is_noise(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  // Extended shift codes emitted around Print Screen / keypad keys are phantom keys.
  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == 8'h12) || (b == 8'h59);
  endfunction

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    push_req  = 1'b0;
    push_data = '0;
    if (err_i) begin
      state_d = IDLE;
      skip_d  = '0;
    end else if (strobe_i) begin
      case (state_q)
        IDLE: begin
          if (code_i == 8'hE0) begin
            state_d = EXT;
          end else if (code_i == 8'hF0) begin
            state_d = BRK;
          end else if (code_i == 8'hE1) begin
            state_d = PAUSE;
            skip_d  = 3'd7;
          end else if (!is_noise(code_i)) begin
            push_req  = 1'b1;
            push_data = {2'b00, code_i};
          end
        end
        EXT: begin
          if (code_i == 8'hF0) begin
            state_d = EXT_BRK;
          end else begin
            state_d = IDLE;
            if (!is_fake_shift(code_i)) begin
              push_req  = 1'b1;
              push_data = {2'b01, code_i};
            end
          end
        end
        BRK: begin
          state_d   = IDLE;
          push_req  = 1'b1;
          push_data = {2'b10, code_i};
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (!is_fake_shift(code_i)) begin
            push_req  = 1'b1;
            push_data = {2'b11, code_i};
          end
        end
        PAUSE: begin
          // Pause has no break code: the whole 8-byte burst maps to one make event.
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d   = IDLE;
            push_req  = 1'b1;
            push_data = 10'h177;
          end
        end
        default: begin
          state_d = IDLE;
          skip_d  = '0;
        end
      endcase
    end
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = rd_i && !empty;
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_overflow_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Storage is not reset, so the head is masked while empty.
  assign key_o      = empty ? 10'h000 : mem[rd_ptr_q];
  assign valid_o    = !empty;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule
